ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 14318000: frequency of clk in Hz.
REQ-002 Parameter INHIBIT_US, default 100: clock-line hold-low time, in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15: abort limit for one transmission, in milliseconds.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tx_data  in  8  command byte to send to the device.
REQ-007 tx_valid  in  1  send request; accepted when tx_valid and tx_ready are both high in the same cycle.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_i  in  1  raw PS/2 clock pad input (asynchronous).
REQ-010 ps2_dat_i  in  1  raw PS/2 data pad input (asynchronous).
REQ-011 ps2_clk_oe  out  1  1 = pull clock pad low; 0 = release (high-Z).
REQ-012 ps2_dat_oe  out  1  1 = pull data pad low; 0 = release.
REQ-013 done  out  1  one-cycle pulse when the device ACK is received.
REQ-014 err  out  1  one-cycle pulse on timeout or missing ACK.
REQ-015 busy  out  1  equals not tx_ready.

Function
REQ-016 Pad inputs SHALL pass through a 2-flop synchroniser; a clock falling edge is the synchronised sample going 1 to 0, detected 3 cycles after the pad edge at most.
REQ-017 The FSM states SHALL be IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK and RELEASE.
REQ-018 IDLE: both oe outputs 0; on accept, latch tx_data, compute odd parity (parity bit = ~^tx_data), clear the bit counter, go to INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES = CLK_HZ*INHIBIT_US/1e6 cycles (1431 at the defaults, integer division); ps2_dat_oe=1 in the last cycle; then go to REQ.
REQ-020 REQ: ps2_clk_oe=0, ps2_dat_oe=1 (start bit); on the first clock falling edge go to DATA.
REQ-021 DATA: on entry and after each falling edge, ps2_dat_oe = ~shift[0]; shift right on each falling edge; after the 8th falling edge go to PARITY; data goes out LSB first.
REQ-022 PARITY: ps2_dat_oe = ~parity; on a falling edge go to STOP.
REQ-023 STOP: ps2_dat_oe=0 (stop bit 1); on a falling edge go to ACK.
REQ-024 ACK: on a falling edge, sampled data 0 -> go to RELEASE; sampled data 1 -> pulse err, go to IDLE.
REQ-025 RELEASE: wait until synchronised clock and data are both 1, then pulse done and go to IDLE.
REQ-026 The timeout counter SHALL start when INHIBIT is left, reset on each accept, and hold while in IDLE; reaching TIMEOUT_CYCLES = CLK_HZ*TIMEOUT_MS/1000 in any non-IDLE state SHALL release both lines, pulse err and return to IDLE in the same cycle.
REQ-027 If the timeout expires in the same cycle as a falling edge, the timeout takes priority.
REQ-028 tx_valid while busy SHALL be ignored; tx_data is sampled only at accept.
REQ-029 done and err SHALL never assert in the same cycle.
REQ-030 A new accept is allowed in the first IDLE cycle after done or err.

Reset
REQ-031 When rst is asserted: state=IDLE; tx_ready=1; busy=0; ps2_clk_oe=0; ps2_dat_oe=0; done=0; err=0; all counters and synchroniser flops at reset value 1 for the line samples.
REQ-032 rst asserted mid-transmission SHALL release both pads immediately (asynchronously), with no done or err pulse.

Structure
REQ-033 A shared package ps2_pkg SHALL hold the FSM state encoding and the INHIBIT_CYCLES and TIMEOUT_CYCLES derivation functions.
REQ-034 Sub-module ps2_sync (2-flop synchroniser plus falling-edge detector) SHALL be instantiated once per line; the sub-module is reused by the PS/2 receiver.

Verification
REQ-035 Send 0xED with the device model clocking at 12.5 kHz and acking -> line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err stays 0.
REQ-036 Send 0x00 -> parity bit is 1; send 0x01 -> parity bit is 0.
REQ-037 Device model never clocks -> err pulses at TIMEOUT_CYCLES (214770) after INHIBIT exits; pads released; tx_ready=1.
REQ-038 Device holds data at 1 in the ACK slot -> err pulse; no done.
REQ-039 Assert rst during DATA bit 4 -> both oe outputs 0 immediately; state IDLE; no pulses.
REQ-040 Assert tx_valid continuously with two bytes -> second byte is accepted only after done; first byte is not corrupted; ps2_clk_oe high measured at exactly 1431 cycles.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks: FSM encoding and timing derivations.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_RELEASE
    } ps2_state_e;

    // Products are formed in 64 bits so large clocks and long timeouts cannot overflow.
    function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                   input int unsigned inhibit_us);
        longint unsigned prod;
        prod = 64'(clk_hz) * 64'(inhibit_us);
        return 32'(prod / 64'd1000000);
    endfunction

    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned timeout_ms);
        longint unsigned prod;
        prod = 64'(clk_hz) * 64'(timeout_ms);
        return 32'(prod / 64'd1000);
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a falling-edge detector on the synchronised level.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pad_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines are high, so reset to 1 avoids a false edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 14318000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       err,
    output logic       busy
);

    import ps2_pkg::*;

    localparam int unsigned INH_CYC = inhibit_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned TMO_CYC = timeout_cycles(CLK_HZ, TIMEOUT_MS);
    localparam int          INH_W   = $clog2(INH_CYC + 1);
    localparam int          TMO_W   = $clog2(TMO_CYC + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;
    logic tmo_run, tmo_hit;

    ps2_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (ps2_clk_i),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync u_dat_sync (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (ps2_dat_i),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    // Timeout window opens once the inhibit pulse is over and holds in IDLE.
    assign tmo_run = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);
    assign tmo_hit = tmo_run && (tmo_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        if (tmo_run && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = ~^tx_data;
                    bit_cnt_d = '0;
                    inh_cnt_d = INH_LOAD;
                    tmo_cnt_d = TMO_LOAD;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = (inh_cnt_q == '0);
                if (inh_cnt_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                ps2_dat_oe = 1'b1;
                if (clk_fall) state_d = ST_DATA;
            end
            ST_DATA: begin
                ps2_dat_oe = ~shift_q[0];
                if (clk_fall) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                ps2_dat_oe = ~parity_q;
                if (clk_fall) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (clk_fall) state_d = ST_ACK;
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (dat_sync) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (clk_sync && dat_sync) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides whatever the current state decided this cycle.
        if (tmo_hit) begin
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
            done       = 1'b0;
            err        = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-collector pad model plus a simple PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH_CYC = 1431;   // 14318000 * 100 / 1e6
    localparam int TMO_CYC = 28636;  // 14318000 * 2 / 1000
    localparam int HALF_SLOW = 573;  // ~12.5 kHz device clock at 14.318 MHz
    localparam int HALF_FAST = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, done, err, busy;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.CLK_HZ(14318000), .INHIBIT_US(100), .TIMEOUT_MS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Pulse counters and inhibit-pulse measurement, sampled on the falling edge.
    int  done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int  run_len = 0, run_dat = 0, inh_len = 0, inh_dat = 0;
    int  since_done = 0, gap = -1;
    logic prev_clk_oe = 1'b0, last_dat = 1'b0, inh_dat_last = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (ps2_clk_oe && !prev_clk_oe) gap = since_done;
        since_done = done ? 0 : since_done + 1;
        if (ps2_clk_oe) begin
            run_len++;
            if (ps2_dat_oe) run_dat++;
            last_dat = ps2_dat_oe;
        end else if (prev_clk_oe) begin
            inh_len = run_len;
            inh_dat = run_dat;
            inh_dat_last = last_dat;
            run_len = 0;
            run_dat = 0;
        end
        prev_clk_oe = ps2_clk_oe;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk_oe(input logic v, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (ps2_clk_oe === v) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, then clocks nfalls cycles, sampling the
    // line just before each falling edge (bits[0] = start ... bits[10] = stop).
    task automatic device(input int half, input int nfalls, input bit ack,
                          output logic [10:0] bits, output bit ok);
        bit ok1, ok2;
        bits = '1;
        wait_clk_oe(1'b1, 100, ok1);
        wait_clk_oe(1'b0, 5000, ok2);
        ok = ok1 & ok2;
        if (!ok) return;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            if (i < 11) bits[i] = ps2_dat_i;
            dev_clk_low = 1'b1;
            if (i == 10 && ack) dev_dat_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i == 11) dev_dat_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        int          half;
        bit          ack;
        logic [10:0] exp_bits;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [10:0] bits, bits2;
        bit ok, ok2, got;
        int d0, e0, n;

        // {stop, parity, data[7:0], start}
        vecs[0] = '{8'hED, HALF_SLOW, 1'b1, 11'h7DA, 1, 0};
        vecs[1] = '{8'h00, HALF_FAST, 1'b1, 11'h600, 1, 0};
        vecs[2] = '{8'h01, HALF_FAST, 1'b1, 11'h402, 1, 0};
        vecs[3] = '{8'hA5, HALF_FAST, 1'b0, 11'h74A, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[v].data);
            device(vecs[v].half, 12, vecs[v].ack, bits, ok);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_dev_start", v), ok, 1);
            check($sformatf("v%0d_line_bits", v), bits, vecs[v].exp_bits);
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_inhibit_len", v), inh_len, INH_CYC);
            check($sformatf("v%0d_inhibit_dat", v), {inh_dat_last, 8'(inh_dat)}, {1'b1, 8'd1});
            check($sformatf("v%0d_ready", v), {tx_ready, busy}, 2'b10);
        end

        // Reset while DATA is driving bit 4 (0x4A has bit 4 = 0, so data is pulled low).
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h4A);
        device(HALF_FAST, 5, 1'b0, bits, ok);
        check("rst_mid_dev_start", ok, 1);
        check("rst_mid_pre_dat_oe", ps2_dat_oe, 1);
        check("rst_mid_pre_busy", {busy, tx_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("rst_mid_idle", {tx_ready, busy}, 2'b10);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Device never clocks: err exactly TMO_CYC cycles after inhibit ends.
        e0 = err_cnt;
        send(8'h55);
        wait_clk_oe(1'b1, 100, ok);
        wait_clk_oe(1'b0, 5000, ok2);
        check("tmo_inhibit_exit", ok & ok2, 1);
        n = 1;
        got = 1'b0;
        while (n < TMO_CYC + 50) begin
            if (err) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("tmo_seen", got, 1);
        check("tmo_cycles", n, TMO_CYC);
        check("tmo_pads", {ps2_clk_oe, ps2_dat_oe, done}, 3'b000);
        @(negedge clk);
        check("tmo_ready", tx_ready, 1);
        check("tmo_err_count", err_cnt - e0, 1);

        // tx_valid held through two frames; data changed right after the first accept.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        wait_clk_oe(1'b1, 100, ok);
        tx_data = 8'hC3;
        device(HALF_FAST, 12, 1'b1, bits, ok2);
        check("b2b_first_start", ok & ok2, 1);
        check("b2b_first_bits", bits, 11'h678);
        check("b2b_first_inhibit", inh_len, INH_CYC);
        wait_clk_oe(1'b1, 100, ok);
        tx_valid = 1'b0;
        check("b2b_second_accept", ok, 1);
        check("b2b_gap_after_done", gap, 1);
        device(HALF_FAST, 12, 1'b1, bits2, ok2);
        repeat (20) @(negedge clk);
        check("b2b_second_start", ok2, 1);
        check("b2b_second_bits", bits2, 11'h786);
        check("b2b_second_inhibit", inh_len, INH_CYC);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_err", err_cnt - e0, 0);
        check("b2b_idle", {tx_ready, ps2_clk_oe, ps2_dat_oe}, 3'b100);

        check("done_err_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
